// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Subtract support is compiled in only when SERIAL_ADDER_SUB_EN is defined.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Counter must hold the values 0..WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_full_adder.sv
// Combinational 1-bit full adder used as the single arithmetic cell of serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through a single full adder.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b with borrow on cout).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_adder_if.slave      bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] result_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             mode_r;
    logic             req_mode_s;
    logic             b_bit_s;
    logic             fa_s;
    logic             fa_co_s;

`ifdef SERIAL_ADDER_SUB_EN
    assign req_mode_s = bus.sub;
    // Subtract is a + ~b + 1: invert b per bit and preload carry with 1.
    assign b_bit_s    = b_sr_r[0] ^ mode_r;
`else
    assign req_mode_s = ADD;
    assign b_bit_s    = b_sr_r[0];
`endif

    full_adder u_fa (
        .a   (a_sr_r[0]),
        .b   (b_bit_s),
        .cin (carry_r),
        .s   (fa_s),
        .co  (fa_co_s)
    );

    // Control FSM, operand shift registers, result assembly and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            result_r <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cout_r   <= 1'b0;
            mode_r   <= ADD;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr_r   <= bus.a;
                        b_sr_r   <= bus.b;
                        result_r <= '0;
                        cnt_r    <= '0;
                        mode_r   <= req_mode_s;
                        carry_r  <= (req_mode_s == SUB) ? 1'b1 : 1'b0;
                        cout_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    result_r <= {fa_s, result_r[WIDTH-1:1]};
                    carry_r  <= fa_co_s;
                    cnt_r    <= cnt_r + CW'(1);
                    busy_r   <= 1'b1;
                    if (cnt_r == LAST_BIT) begin
                        // In subtract mode a missing carry-out means a borrow occurred.
                        cout_r  <= fa_co_s ^ mode_r;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = result_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors plus a cycle-level reference model.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Golden arithmetic: {carry/borrow, result}.
    function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic s);
        logic [WIDTH:0] r;
        if (s) begin
            r[WIDTH-1:0] = x - y;
            r[WIDTH]     = (x < y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    // Reference model: phase counts cycles since the accepted start (0 = idle).
    int             m_phase;
    logic [WIDTH:0] m_pend;
    logic [WIDTH-1:0] m_sum;
    logic           m_cout;
    logic           m_req_sub;

`ifdef SERIAL_ADDER_SUB_EN
    assign m_req_sub = bus.sub;
`else
    assign m_req_sub = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_pend  <= '0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_pend  <= golden(bus.a, bus.b, m_req_sub);
                m_sum   <= '0;
                m_cout  <= 1'b0;
                m_phase <= 1;
            end
        end else if (m_phase == WIDTH) begin
            m_sum   <= m_pend[WIDTH-1:0];
            m_cout  <= m_pend[WIDTH];
            m_phase <= WIDTH + 1;
        end else if (m_phase == WIDTH + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // Compare outputs against the model every cycle; sum/cout only when they are meaningful.
    always @(negedge clk) begin
        check("model_busy", 64'(bus.busy), 64'(m_phase != 0));
        check("model_done", 64'(bus.done), 64'(m_phase == WIDTH + 1));
        if (m_phase == 0 || m_phase == WIDTH + 1) begin
            check("model_sum", 64'(bus.sum), 64'(m_sum));
            check("model_cout", 64'(bus.cout), 64'(m_cout));
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                          input bit noisy);
        int k;
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = s;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < WIDTH + 4) begin
            if (noisy) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
                bus.sub   = ~s;
`endif
            end
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'(WIDTH));
        check({name, "_sum"}, 64'(bus.sum), 64'(exp_sum));
        check({name, "_cout"}, 64'(bus.cout), 64'(exp_cout));
        if (noisy) bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({name, "_done_after"}, 64'(bus.done), 64'd0);
        check({name, "_sum_hold"}, 64'(bus.sum), 64'(exp_sum));
    endtask

    initial begin
        logic [WIDTH:0]   g;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               t_done[$];
        int               cyc;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_25_17", 8'd25, 8'd17, 1'b0, 8'd42, 1'b0, 1'b0);
        run_op("add_255_1", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
        run_op("add_128_128", 8'd128, 8'd128, 1'b0, 8'd0, 1'b1, 1'b0);
        run_op("add_0_0", 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        run_op("add_noisy", 8'd100, 8'd55, 1'b0, 8'd155, 1'b0, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_5_7", 8'd5, 8'd7, 1'b1, 8'd254, 1'b1, 1'b0);
        run_op("sub_7_5", 8'd7, 8'd5, 1'b1, 8'd2, 1'b0, 1'b0);
        run_op("sub_200_200", 8'd200, 8'd200, 1'b1, 8'd0, 1'b0, 1'b0);
        run_op("sub_noisy", 8'd3, 8'd9, 1'b1, 8'd250, 1'b1, 1'b1);
`endif

        // start held high: results come back WIDTH+2 cycles apart.
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd25;
        bus.b     = 8'd17;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        cyc = 0;
        while (t_done.size() < 2 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) begin
                t_done.push_back(cyc);
                check("b2b_sum", 64'(bus.sum), 64'd42);
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 64'(t_done.size()), 64'd2);
        if (t_done.size() == 2) check("b2b_spacing", 64'(t_done[1] - t_done[0]), 64'(WIDTH + 2));

        // Reset in the middle of an operation discards it without a done pulse.
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd25;
        bus.b     = 8'd17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_sum", 64'(bus.sum), 64'd0);
        check("midrst_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_done", 64'(bus.done), 64'd0);
        end
        run_op("after_rst", 8'd25, 8'd17, 1'b0, 8'd42, 1'b0, 1'b0);

        // Random operands, expectations from the golden arithmetic.
        for (int i = 0; i < 150; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            g  = golden(ra, rb, 1'b0);
            run_op("rand_add", ra, rb, 1'b0, g[WIDTH-1:0], g[WIDTH], 1'($urandom_range(0, 1)));
        end
`ifdef SERIAL_ADDER_SUB_EN
        for (int i = 0; i < 150; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            g  = golden(ra, rb, 1'b1);
            run_op("rand_sub", ra, rb, 1'b1, g[WIDTH-1:0], g[WIDTH], 1'($urandom_range(0, 1)));
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
